apb_acc_regif: RTL
==================

// Module: apb_acc_regif
// PURPOSE
//  Parametrised APB slave front-end for a start/done matrix accelerator. Holds
//  the operand A/B buffers and a captured result buffer, and runs a start/busy/
//  done FSM with cycle counter, timeout and interrupt. Sits between the
//  peripheral APB bus and the accelerator core; accelerator runs on HCLK.
// PARAMETERS
//  APB_ADDR_WIDTH  12    PADDR bits decoded (byte address, word aligned)
//  N_WORDS         2     32-bit words per operand/result buffer (1..256)
//  TIMEOUT_W       16    width of cycle counter; timeout at 2**TIMEOUT_W-1
// PORTS
//  HCLK       in   1               clock
//  HRESETn    in   1               async reset, active low
//  PADDR      in   APB_ADDR_WIDTH  APB address
//  PWDATA     in   32              APB write data
//  PWRITE     in   1               APB write
//  PSEL       in   1               APB select
//  PENABLE    in   1               APB enable
//  PRDATA     out  32              APB read data
//  PREADY     out  1               always 1 (zero wait state)
//  PSLVERR    out  1               error on rejected/unmapped access
//  acc_start  out  1               one-cycle start pulse to core
//  acc_done   in   1               core completion pulse (level accepted)
//  acc_in_a   out  32*N_WORDS      operand A buffer, word i at [32i+:32]
//  acc_in_b   out  32*N_WORDS      operand B buffer
//  acc_out    in   32*N_WORDS      core result, sampled when acc_done seen
//  irq        out  1               STATUS.done & CTRL.irq_en
// BEHAVIOUR
//  Reset: HRESETn async active low; clock HCLK. All buffers, CTRL, STATUS,
//   CYCLES, result buffer = 0; FSM IDLE; acc_start=0, irq=0, PSLVERR=0.
//  Access phase = PSEL&PENABLE; writes take effect on that HCLK edge.
//  Map (byte offsets): 0x000 CTRL  [0] start (W1, reads 0), [1] irq_en RW
//   0x004 STATUS [0] busy RO, [1] done W1C, [2] timeout W1C
//   0x008 CYCLES RO, cycles of last run, zero-extended
//   0x400+4i A[i], 0x800+4i B[i] RW; 0xC00+4i RES[i] RO; i<N_WORDS.
//  Unmapped addr, write to RO reg, or index >=N_WORDS: PSLVERR=1, no state
//   change, PRDATA=0. PRDATA combinational from registers, else 0.
//  FSM: IDLE --(write CTRL[0]=1)--> START: acc_start=1 one cycle, counter=0,
//   busy=1 --> WAIT: counter++ each cycle; acc_done=1 -> capture acc_out into
//   RES, CYCLES=counter, done=1 -> IDLE; counter==max -> timeout=1, CYCLES=max,
//   RES unchanged -> IDLE. busy=1 in START and WAIT.
//  While busy: writes to CTRL.start, A, B -> PSLVERR=1, ignored; reads OK;
//   CTRL.irq_en and STATUS W1C writes still accepted.
//  Starting run does not clear done/timeout; software clears via W1C.
//  Same-cycle set and W1C clear of done/timeout: set wins.
//  acc_done in IDLE/START ignored. Start write with PWDATA[0]=0 only
//   updates irq_en.
//  Counter saturates, never wraps. Reset mid-run: FSM to IDLE, all cleared.
// TESTING
//  1 Reset; read 0x000/0x004/0xC00 -> 0, PSLVERR=0; irq=0.
//  2 Write A0=0x04030201,B0=0x08070605, start; core done after 5 cycles with
//    acc_out word0=0xDEADBEEF -> acc_start 1-cycle pulse, STATUS=0x2, CYCLES=5,
//    RES0=0xDEADBEEF.
//  3 Write A1=0x11111111 while busy -> PSLVERR=1, A1 unchanged; start again
//    while busy -> PSLVERR=1, single acc_start only.
//  4 irq_en=1, run to done -> irq=1; W1C 0x2 to STATUS -> irq=0 next cycle;
//    W1C coinciding with new done -> done stays 1.
//  5 TIMEOUT_W=4, core never done -> after 15 WAIT cycles STATUS=0x4,
//    CYCLES=15, busy=0, RES unchanged.
//  6 Read 0x404*N_WORDS-beyond/0x010 -> PSLVERR=1, PRDATA=0; HRESETn low
//    mid-run -> busy=0, buffers 0.

Source files
------------

// File: rtl/apb_acc_regif.sv
// APB register front-end for a start/done matrix accelerator: operand/result
// buffers, CTRL/STATUS/CYCLES registers and the run FSM with timeout and irq.
module apb_acc_regif #(
    parameter int unsigned APB_ADDR_WIDTH = 12,  // at least 12
    parameter int unsigned N_WORDS        = 2,   // 1..256
    parameter int unsigned TIMEOUT_W      = 16   // at most 32
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
    input  logic [31:0]                 PWDATA,
    input  logic                        PWRITE,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    output logic [31:0]                 PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERR,
    output logic                        acc_start,
    input  logic                        acc_done,
    output logic [32*N_WORDS-1:0]       acc_in_a,
    output logic [32*N_WORDS-1:0]       acc_in_b,
    input  logic [32*N_WORDS-1:0]       acc_out,
    output logic                        irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 8;
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   acc_start_q, acc_start_d;
    logic                   busy_c, run_done_c, run_to_c;

    logic [TIMEOUT_W-1:0]   cnt_q;
    logic [TIMEOUT_W-1:0]   cycles_q;
    logic                   irq_en_q, irq_en_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   irq_q;

    logic [DATA_W-1:0]      a_q   [N_WORDS];
    logic [DATA_W-1:0]      b_q   [N_WORDS];
    logic [DATA_W-1:0]      res_q [N_WORDS];

    // Address decode
    logic                   access_c, upper_ok_c, idx_ok_c;
    logic [1:0]             region_c;
    logic [IDX_W-1:0]       idx_c;
    logic                   sel_ctrl_c, sel_status_c, sel_cycles_c;
    logic                   sel_a_c, sel_b_c, sel_res_c;
    logic                   mapped_c, err_c, wr_ok_c;
    logic                   start_req_c, w1c_done_c, w1c_to_c;
    logic [DATA_W-1:0]      rdata_c;

    if (APB_ADDR_WIDTH > 12) begin : g_hi_addr
        assign upper_ok_c = (PADDR[APB_ADDR_WIDTH-1:12] == '0) && (PADDR[1:0] == 2'b00);
    end else begin : g_no_hi_addr
        assign upper_ok_c = (PADDR[1:0] == 2'b00);
    end

    assign access_c     = PSEL & PENABLE;
    assign region_c     = PADDR[11:10];
    assign idx_c        = PADDR[9:2];
    assign idx_ok_c     = (32'(idx_c) < N_WORDS);

    assign sel_ctrl_c   = upper_ok_c && (region_c == 2'd0) && (idx_c == IDX_W'(0));
    assign sel_status_c = upper_ok_c && (region_c == 2'd0) && (idx_c == IDX_W'(1));
    assign sel_cycles_c = upper_ok_c && (region_c == 2'd0) && (idx_c == IDX_W'(2));
    assign sel_a_c      = upper_ok_c && (region_c == 2'd1) && idx_ok_c;
    assign sel_b_c      = upper_ok_c && (region_c == 2'd2) && idx_ok_c;
    assign sel_res_c    = upper_ok_c && (region_c == 2'd3) && idx_ok_c;
    assign mapped_c     = sel_ctrl_c | sel_status_c | sel_cycles_c | sel_a_c | sel_b_c | sel_res_c;

    // Rejected accesses: unmapped, RO targets, or operand/start writes mid-run
    assign err_c = ~mapped_c
                 | (PWRITE & (sel_cycles_c | sel_res_c
                              | (busy_c & (sel_a_c | sel_b_c | (sel_ctrl_c & PWDATA[0])))));

    assign wr_ok_c     = access_c & PWRITE & ~err_c;
    assign start_req_c = wr_ok_c & sel_ctrl_c & PWDATA[0];
    assign w1c_done_c  = wr_ok_c & sel_status_c & PWDATA[1];
    assign w1c_to_c    = wr_ok_c & sel_status_c & PWDATA[2];

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_req_c) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (acc_done || (cnt_q == CNT_MAX)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; done beats timeout when both land on the last cycle
    always_comb begin
        busy_c      = (state_q != ST_IDLE);
        acc_start_d = (state_d == ST_START);
        run_done_c  = (state_q == ST_WAIT) && acc_done;
        run_to_c    = (state_q == ST_WAIT) && !acc_done && (cnt_q == CNT_MAX);
    end

    // Sticky status bits: a same-cycle set overrides the W1C clear
    always_comb begin
        done_d    = run_done_c | (done_q & ~w1c_done_c);
        timeout_d = run_to_c   | (timeout_q & ~w1c_to_c);
        irq_en_d  = (wr_ok_c && sel_ctrl_c) ? PWDATA[1] : irq_en_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            acc_start_q <= 1'b0;
            cnt_q       <= '0;
            cycles_q    <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            acc_start_q <= acc_start_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            irq_q       <= done_d & irq_en_d;
            // Counter reads k in the k-th cycle after the start pulse
            if (start_req_c)
                cnt_q <= '0;
            else if (busy_c && (cnt_q != CNT_MAX))
                cnt_q <= cnt_q + TIMEOUT_W'(1);
            if (run_done_c)
                cycles_q <= cnt_q;
            else if (run_to_c)
                cycles_q <= CNT_MAX;
        end
    end

    // Operand and result buffers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < N_WORDS; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_WORDS; i++) begin
                if (wr_ok_c && sel_a_c && (idx_c == IDX_W'(i)))
                    a_q[i] <= PWDATA;
                if (wr_ok_c && sel_b_c && (idx_c == IDX_W'(i)))
                    b_q[i] <= PWDATA;
                if (run_done_c)
                    res_q[i] <= acc_out[DATA_W*i +: DATA_W];
            end
        end
    end

    // Read mux; rejected or idle accesses return zero
    always_comb begin
        rdata_c = '0;
        if (PSEL && !PWRITE && !err_c) begin
            if (sel_ctrl_c)   rdata_c = {30'b0, irq_en_q, 1'b0};
            if (sel_status_c) rdata_c = {29'b0, timeout_q, done_q, busy_c};
            if (sel_cycles_c) rdata_c = 32'(cycles_q);
            for (int i = 0; i < N_WORDS; i++) begin
                if (idx_c == IDX_W'(i)) begin
                    if (sel_a_c)   rdata_c = a_q[i];
                    if (sel_b_c)   rdata_c = b_q[i];
                    if (sel_res_c) rdata_c = res_q[i];
                end
            end
        end
    end

    for (genvar i = 0; i < N_WORDS; i++) begin : g_flat
        assign acc_in_a[DATA_W*i +: DATA_W] = a_q[i];
        assign acc_in_b[DATA_W*i +: DATA_W] = b_q[i];
    end

    assign PRDATA    = rdata_c;
    assign PREADY    = 1'b1;
    assign PSLVERR   = access_c & err_c;
    assign acc_start = acc_start_q;
    assign irq       = irq_q;

endmodule
